// File: rtl/kmeans_accum_ctrl_if.sv
// Point/classifier/result bundle for the k-means accumulation controller.
// master is the environment side, slave is the controller side.
interface kmeans_accum_ctrl_if #(
    parameter int n  = 8,
    parameter int d  = 2,
    parameter int sw = 48
);
    logic                     start;
    logic [31:0]              n_points;
    logic                     point_valid;
    logic                     point_ready;
    logic [d-1:0][31:0]       point;
    logic [d-1:0][31:0]       cls_point;
    logic [31:0]              cls_id;
    logic                     out_valid;
    logic                     out_ready;
    logic [n-1:0]             out_class;
    logic [d-1:0][sw-1:0]     out_sum;
    logic [31:0]              out_count;
    logic                     busy;
    logic                     done;

    modport master (
        output start, n_points, point_valid, point, cls_id, out_ready,
        input  point_ready, cls_point, out_valid, out_class, out_sum, out_count, busy, done
    );

    modport slave (
        input  start, n_points, point_valid, point, cls_id, out_ready,
        output point_ready, cls_point, out_valid, out_class, out_sum, out_count, busy, done
    );
endinterface

// File: rtl/kmeans_accum_ctrl.sv
// Per-class coordinate-sum and count accumulator for one k-means pass:
// clear all entries, accumulate classified points, then drain results in class order.
module kmeans_accum_ctrl #(
    parameter int n  = 8,
    parameter int d  = 2,
    parameter int sw = 48
) (
    input logic               clk,
    input logic               rst,
    kmeans_accum_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, FLUSH, DRAIN} state_t;

    state_t                state;
    logic [n-1:0]          idx;
    logic [31:0]           n_pts;
    logic [31:0]           acc_cnt;
    logic                  pending;
    logic                  accept;
    logic                  drain_hs;
    logic [n-1:0]          upd_id;
    logic                  unused_cls_bits;

    logic [d-1:0][sw-1:0]  sum_mem [2**n];
    logic [31:0]           cnt_mem [2**n];

    assign upd_id          = bus.cls_id[n-1:0];
    assign unused_cls_bits = ^bus.cls_id[31:n];

    assign bus.point_ready = (state == ACCUM) && (acc_cnt < n_pts);
    assign accept          = bus.point_valid && bus.point_ready;
    assign drain_hs        = bus.out_valid && bus.out_ready;

    assign bus.out_class   = idx;
    assign bus.out_sum     = bus.out_valid ? sum_mem[idx] : '0;
    assign bus.out_count   = bus.out_valid ? cnt_mem[idx] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            n_pts         <= '0;
            acc_cnt       <= '0;
            pending       <= 1'b0;
            bus.cls_point <= '0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            pending  <= accept;
            if (accept) begin
                bus.cls_point <= bus.point;
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        n_pts    <= bus.n_points;
                        acc_cnt  <= '0;
                        idx      <= '0;
                        bus.busy <= 1'b1;
                        state    <= CLEAR;
                    end
                end
                CLEAR: begin
                    idx <= idx + 1'b1;
                    if (idx == {n{1'b1}}) begin
                        if (n_pts != 32'd0) begin
                            state <= ACCUM;
                        end else begin
                            bus.out_valid <= 1'b1;
                            state         <= DRAIN;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_cnt <= acc_cnt + 32'd1;
                        if (acc_cnt + 32'd1 == n_pts) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    bus.out_valid <= 1'b1;
                    state         <= DRAIN;
                end
                DRAIN: begin
                    if (drain_hs) begin
                        idx <= idx + 1'b1;
                        if (idx == {n{1'b1}}) begin
                            bus.out_valid <= 1'b0;
                            bus.busy      <= 1'b0;
                            bus.done      <= 1'b1;
                            state         <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Single-cycle read-modify-write keeps same-class back-to-back updates coherent.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            sum_mem[idx] <= '0;
            cnt_mem[idx] <= '0;
        end else if (pending) begin
            for (int j = 0; j < d; j++) begin
                sum_mem[upd_id][j] <= sum_mem[upd_id][j] + sw'(bus.cls_point[j]);
            end
            cnt_mem[upd_id] <= cnt_mem[upd_id] + 32'd1;
        end
    end
endmodule

// File: tb/tb_kmeans_accum_ctrl.sv
// Scoreboard bench for kmeans_accum_ctrl: directed passes push expected per-class
// results into a queue, and a monitor pops and compares on every drain handshake.
module tb_kmeans_accum_ctrl;
    localparam int N  = 2;
    localparam int D  = 2;
    localparam int SW = 48;
    localparam int NC = 1 << N;

    typedef struct {
        logic [N-1:0]  cls;
        logic [SW-1:0] s0;
        logic [SW-1:0] s1;
        logic [31:0]   cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errs   = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    kmeans_accum_ctrl_if #(.n(N), .d(D), .sw(SW)) bus ();
    kmeans_accum_ctrl #(.n(N), .d(D), .sw(SW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Classifier stand-in keyed on the first coordinate.
    function automatic logic [31:0] classify(input logic [31:0] x);
        case (x)
            32'd3:   return 32'd1;
            32'd7:   return 32'd2;
            32'd10:  return 32'd3;
            default: return 32'd0;
        endcase
    endfunction

    always_comb bus.cls_id = classify(bus.cls_point[0]);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input int cls, input logic [SW-1:0] s0, input logic [SW-1:0] s1,
                        input logic [31:0] cnt);
        exp_t e;
        e.cls = cls[N-1:0];
        e.s0  = s0;
        e.s1  = s1;
        e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (bus.done) done_cnt++;
        if (!rst && bus.out_valid && bus.out_ready) begin
            chk("result_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("out_class", 64'(bus.out_class), 64'(mon_e.cls));
                chk("out_sum0",  64'(bus.out_sum[0]), 64'(mon_e.s0));
                chk("out_sum1",  64'(bus.out_sum[1]), 64'(mon_e.s1));
                chk("out_count", 64'(bus.out_count), 64'(mon_e.cnt));
            end
        end
    end

    task automatic start_pass(input logic [31:0] np);
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.n_points = np;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("busy_after_start", 64'(bus.busy), 64'd1);
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] y, output int waits);
        bus.point_valid = 1'b1;
        bus.point[0]    = x;
        bus.point[1]    = y;
        waits           = 0;
        forever begin
            @(negedge clk);
            if (bus.point_ready) break;
            waits++;
            if (waits > 500) begin
                chk("point_ready_timeout", 64'(bus.point_ready), 64'd1);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input int prev);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.done) break;
        end
        repeat (3) @(negedge clk);
        chk("done_pulses", 64'(done_cnt - prev), 64'd1);
        chk("busy_after_done", 64'(bus.busy), 64'd0);
        chk("drain_complete", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int w;
        int prev;
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.n_points    = '0;
        bus.point_valid = 1'b0;
        bus.point       = '0;
        bus.out_ready   = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("rst_point_ready", 64'(bus.point_ready), 64'd0);
        chk("rst_out_valid",   64'(bus.out_valid), 64'd0);
        chk("rst_busy",        64'(bus.busy), 64'd0);
        chk("rst_done",        64'(bus.done), 64'd0);
        chk("rst_out_class",   64'(bus.out_class), 64'd0);
        chk("rst_cls_point",   64'(bus.cls_point), 64'd0);
        chk("rst_out_sum",     64'(bus.out_sum), 64'd0);
        chk("rst_out_count",   64'(bus.out_count), 64'd0);
        rst = 1'b0;

        // Three points mapped 0,1,0 with the drain stalled at index 0.
        bus.out_ready = 1'b0;
        prev = done_cnt;
        push(0, 6, 8, 2); push(1, 3, 4, 1); push(2, 0, 0, 0); push(3, 0, 0, 0);
        start_pass(3);
        send(1, 2, w); send(3, 4, w); send(5, 6, w);
        bus.point_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.out_valid) break;
        end
        for (int k = 0; k < 5; k++) begin
            chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_out_class", 64'(bus.out_class), 64'd0);
            chk("stall_out_sum0",  64'(bus.out_sum[0]), 64'd6);
            chk("stall_out_sum1",  64'(bus.out_sum[1]), 64'd8);
            chk("stall_out_count", 64'(bus.out_count), 64'd2);
            chk("cls_point_hold",  64'(bus.cls_point[0]), 64'd5);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_done(prev);

        // Empty pass.
        prev = done_cnt;
        for (int c = 0; c < NC; c++) push(c, 0, 0, 0);
        start_pass(0);
        wait_done(prev);

        // Four back-to-back points into the same class.
        prev = done_cnt;
        push(0, 0, 0, 0); push(1, 0, 0, 0); push(2, 0, 0, 0); push(3, 40, 80, 4);
        start_pass(4);
        send(10, 20, w);
        for (int k = 0; k < 3; k++) begin
            send(10, 20, w);
            chk("b2b_ready_wait", 64'(w), 64'd0);
        end
        @(negedge clk);
        chk("ready_low_after_last", 64'(bus.point_ready), 64'd0);
        bus.point_valid = 1'b0;
        wait_done(prev);

        // Abort mid-accumulation, then a fresh single-point pass.
        prev = done_cnt;
        start_pass(5);
        send(7, 1, w); send(3, 2, w);
        bus.point_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("abort_busy",        64'(bus.busy), 64'd0);
        chk("abort_point_ready", 64'(bus.point_ready), 64'd0);
        chk("abort_out_valid",   64'(bus.out_valid), 64'd0);
        chk("abort_cls_point",   64'(bus.cls_point), 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_done_on_abort", 64'(done_cnt - prev), 64'd0);
        prev = done_cnt;
        push(0, 0, 0, 0); push(1, 0, 0, 0); push(2, 0, 0, 0); push(3, 10, 20, 1);
        start_pass(1);
        send(10, 20, w);
        bus.point_valid = 1'b0;
        wait_done(prev);

        // Sum wrap: (2**16+1) * 0xFFFFFFFF mod 2**48 = 0xFFFEFFFF.
        prev = done_cnt;
        push(0, 48'h0000_FFFE_FFFF, 0, 32'd65537);
        push(1, 0, 0, 0); push(2, 0, 0, 0); push(3, 0, 0, 0);
        start_pass(32'd65537);
        for (int k = 0; k < 65537; k++) send(32'hFFFF_FFFF, 32'd0, w);
        bus.point_valid = 1'b0;
        wait_done(prev);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
